mem_port_arbiter: RTL and testbench

- Shares the single-port program/data memory between two requesters.
- Requester 0 is the CPU controller, driving the fetch/operand read/write strobes.
- Requester 1 is the program loader / debug port, which writes or reads memory while the CPU runs or stalls.
- Round-robin arbitration, a fixed multicycle memory access latency, and a req/done handshake that a Moore-style controller FSM can wait on.

---
 rtl/mem_arb_pkg.sv | 34 +++
 rtl/mem_lat_counter.sv | 30 +++
 rtl/mem_port_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter: FSM states, owner encoding,
// default bus widths and the round-robin pick helper.
package mem_arb_pkg;

    localparam int MEM_ARB_AW = 12;
    localparam int MEM_ARB_DW = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_LDR = 1'b1
    } owner_t;

    // On a tie the requester that did not own the port last time wins.
    function automatic owner_t arb_pick(input logic cpu_req, input logic ldr_req, input owner_t last_owner);
        if (cpu_req && ldr_req) begin
            if (last_owner == OWN_CPU) begin
                return OWN_LDR;
            end else begin
                return OWN_CPU;
            end
        end else if (ldr_req) begin
            return OWN_LDR;
        end else begin
            return OWN_CPU;
        end
    endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter with zero flag; times the fixed memory access latency.
module mem_lat_counter #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    input  logic          i_dec,
    output logic          o_zero
);

    logic [CW-1:0] r_cnt;

    assign o_zero = (r_cnt == {CW{1'b0}});

    // Counter register: load has priority over decrement.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= {CW{1'b0}};
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec) begin
            r_cnt <= r_cnt - CW'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the single-port memory between CPU and loader/debug port.
// Optional loader lock (atomic load bursts) is enabled by defining MEM_ARB_LDR_LOCK_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = MEM_ARB_AW,
    parameter int DW      = MEM_ARB_DW,
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_done,
    input  logic          ldr_req,
    input  logic          ldr_we,
    input  logic [AW-1:0] ldr_addr,
    input  logic [DW-1:0] ldr_wdata,
`ifdef MEM_ARB_LDR_LOCK_EN
    input  logic          ldr_lock,
`endif
    output logic          ldr_gnt,
    output logic          ldr_done,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int CW = $clog2(MEM_LAT) + 1;

    arb_state_t    r_state, w_nxt_state;
    owner_t        r_owner, w_nxt_owner;
    owner_t        r_last, w_nxt_last;
    owner_t        w_win;
    logic          r_mem_en, w_nxt_mem_en;
    logic          r_mem_we, w_nxt_mem_we;
    logic [AW-1:0] r_mem_addr, w_nxt_mem_addr;
    logic [DW-1:0] r_mem_wdata, w_nxt_mem_wdata;
    logic          r_cpu_gnt, w_nxt_cpu_gnt;
    logic          r_cpu_done, w_nxt_cpu_done;
    logic          r_ldr_gnt, w_nxt_ldr_gnt;
    logic          r_ldr_done, w_nxt_ldr_done;
    logic [DW-1:0] r_rdata, w_nxt_rdata;
    logic          w_cnt_load;
    logic          w_cnt_dec;
    logic          w_cnt_zero;
    logic          w_lock_hold;

`ifdef MEM_ARB_LDR_LOCK_EN
    logic          r_lock, w_nxt_lock;
    assign w_lock_hold = r_lock & ldr_req;
`else
    assign w_lock_hold = 1'b0;
`endif

    // A held lock forces the loader to win without advancing the round-robin pointer.
    assign w_win = w_lock_hold ? OWN_LDR : arb_pick(cpu_req, ldr_req, r_last);

    mem_lat_counter #(
        .CW (CW)
    ) u_lat_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_load_val (CW'(MEM_LAT - 1)),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    // Next-state and next-output logic; all outputs are registered below.
    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_owner     = r_owner;
        w_nxt_last      = r_last;
        w_nxt_mem_en    = r_mem_en;
        w_nxt_mem_we    = r_mem_we;
        w_nxt_mem_addr  = r_mem_addr;
        w_nxt_mem_wdata = r_mem_wdata;
        w_nxt_cpu_gnt   = r_cpu_gnt;
        w_nxt_ldr_gnt   = r_ldr_gnt;
        w_nxt_cpu_done  = 1'b0;
        w_nxt_ldr_done  = 1'b0;
        w_nxt_rdata     = r_rdata;
        w_cnt_load      = 1'b0;
        w_cnt_dec       = 1'b0;
`ifdef MEM_ARB_LDR_LOCK_EN
        w_nxt_lock      = r_lock;
`endif
        case (r_state)
            IDLE: begin
`ifdef MEM_ARB_LDR_LOCK_EN
                w_nxt_lock = w_lock_hold;
`endif
                if (cpu_req || ldr_req) begin
                    w_nxt_state  = BUSY;
                    w_nxt_owner  = w_win;
                    w_nxt_mem_en = 1'b1;
                    w_cnt_load   = 1'b1;
                    if (!w_lock_hold) begin
                        w_nxt_last = w_win;
                    end else begin
                        w_nxt_last = r_last;
                    end
                    // Only the winner's bus is sampled.
                    if (w_win == OWN_CPU) begin
                        w_nxt_mem_we    = cpu_we;
                        w_nxt_mem_addr  = cpu_addr;
                        w_nxt_mem_wdata = cpu_wdata;
                        w_nxt_cpu_gnt   = 1'b1;
                        w_nxt_ldr_gnt   = 1'b0;
                    end else begin
                        w_nxt_mem_we    = ldr_we;
                        w_nxt_mem_addr  = ldr_addr;
                        w_nxt_mem_wdata = ldr_wdata;
                        w_nxt_cpu_gnt   = 1'b0;
                        w_nxt_ldr_gnt   = 1'b1;
                    end
                end else begin
                    w_nxt_state = IDLE;
                end
            end
            BUSY: begin
                if (w_cnt_zero) begin
                    w_nxt_state  = DONE;
                    w_nxt_mem_en = 1'b0;
                    w_nxt_mem_we = 1'b0;
                    if (r_owner == OWN_CPU) begin
                        w_nxt_cpu_done = 1'b1;
                    end else begin
                        w_nxt_ldr_done = 1'b1;
                    end
                    if (!r_mem_we) begin
                        w_nxt_rdata = mem_rdata;
                    end else begin
                        w_nxt_rdata = r_rdata;
                    end
`ifdef MEM_ARB_LDR_LOCK_EN
                    if (r_owner == OWN_LDR) begin
                        w_nxt_lock = ldr_lock;
                    end else begin
                        w_nxt_lock = r_lock;
                    end
`endif
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            DONE: begin
                w_nxt_state   = IDLE;
                w_nxt_cpu_gnt = 1'b0;
                w_nxt_ldr_gnt = 1'b0;
            end
            default: begin
                w_nxt_state   = IDLE;
                w_nxt_mem_en  = 1'b0;
                w_nxt_mem_we  = 1'b0;
                w_nxt_cpu_gnt = 1'b0;
                w_nxt_ldr_gnt = 1'b0;
            end
        endcase
    end

    // State and output registers; reset leaves the CPU winning the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_owner     <= OWN_CPU;
            r_last      <= OWN_LDR;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= {AW{1'b0}};
            r_mem_wdata <= {DW{1'b0}};
            r_cpu_gnt   <= 1'b0;
            r_cpu_done  <= 1'b0;
            r_ldr_gnt   <= 1'b0;
            r_ldr_done  <= 1'b0;
            r_rdata     <= {DW{1'b0}};
`ifdef MEM_ARB_LDR_LOCK_EN
            r_lock      <= 1'b0;
`endif
        end else begin
            r_state     <= w_nxt_state;
            r_owner     <= w_nxt_owner;
            r_last      <= w_nxt_last;
            r_mem_en    <= w_nxt_mem_en;
            r_mem_we    <= w_nxt_mem_we;
            r_mem_addr  <= w_nxt_mem_addr;
            r_mem_wdata <= w_nxt_mem_wdata;
            r_cpu_gnt   <= w_nxt_cpu_gnt;
            r_cpu_done  <= w_nxt_cpu_done;
            r_ldr_gnt   <= w_nxt_ldr_gnt;
            r_ldr_done  <= w_nxt_ldr_done;
            r_rdata     <= w_nxt_rdata;
`ifdef MEM_ARB_LDR_LOCK_EN
            r_lock      <= w_nxt_lock;
`endif
        end
    end

    assign cpu_gnt   = r_cpu_gnt;
    assign cpu_done  = r_cpu_done;
    assign ldr_gnt   = r_ldr_gnt;
    assign ldr_done  = r_ldr_done;
    assign rdata     = r_rdata;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Table-driven bench for mem_port_arbiter (MEM_LAT=2), plus hand-written reset-mid-busy
// and loader-lock sequences (the latter only when MEM_ARB_LDR_LOCK_EN is defined).
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [11:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_gnt, cpu_done;
    logic        ldr_req, ldr_we;
    logic [11:0] ldr_addr;
    logic [15:0] ldr_wdata;
    logic        ldr_gnt, ldr_done;
    logic [15:0] rdata;
    logic        mem_en, mem_we;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
`ifdef MEM_ARB_LDR_LOCK_EN
    logic        ldr_lock;
`endif

    mem_port_arbiter #(.AW(12), .DW(16), .MEM_LAT(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_gnt   (cpu_gnt),
        .cpu_done  (cpu_done),
        .ldr_req   (ldr_req),
        .ldr_we    (ldr_we),
        .ldr_addr  (ldr_addr),
        .ldr_wdata (ldr_wdata),
`ifdef MEM_ARB_LDR_LOCK_EN
        .ldr_lock  (ldr_lock),
`endif
        .ldr_gnt   (ldr_gnt),
        .ldr_done  (ldr_done),
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Packed observation: {mem_en, mem_we, mem_addr, mem_wdata, cpu_gnt, cpu_done, ldr_gnt, ldr_done, rdata}
    logic [49:0] act;
    assign act = {mem_en, mem_we, mem_addr, mem_wdata, cpu_gnt, cpu_done, ldr_gnt, ldr_done, rdata};

    typedef struct {
        logic        rb;
        logic        creq, cwe;
        logic [11:0] caddr;
        logic [15:0] cwd;
        logic        lreq, lwe;
        logic [11:0] laddr;
        logic [15:0] lwd;
        logic [15:0] mrd;
        logic [49:0] want;
    } vec_t;

    vec_t tbl[$];
    int   n_vec;
    int   n_err;

    function automatic logic [49:0] pk(input logic en, input logic we, input logic [11:0] a, input logic [15:0] wd,
                                        input logic cg, input logic cd, input logic lg, input logic ld, input logic [15:0] rd);
        return {en, we, a, wd, cg, cd, lg, ld, rd};
    endfunction

    task automatic v(input logic rb, input logic creq, input logic cwe, input logic [11:0] caddr, input logic [15:0] cwd,
                     input logic lreq, input logic lwe, input logic [11:0] laddr, input logic [15:0] lwd,
                     input logic [15:0] mrd, input logic [49:0] want);
        vec_t e;
        e.rb = rb; e.creq = creq; e.cwe = cwe; e.caddr = caddr; e.cwd = cwd;
        e.lreq = lreq; e.lwe = lwe; e.laddr = laddr; e.lwd = lwd; e.mrd = mrd; e.want = want;
        tbl.push_back(e);
    endtask

    // Both requesters active: CPU reads 0x010, loader writes 0xAAAA to 0x020.
    task automatic t2(input logic rb, input logic [15:0] mrd, input logic [49:0] want);
        v(rb, 1'b1, 1'b0, 12'h010, 16'h5555, 1'b1, 1'b1, 12'h020, 16'hAAAA, mrd, want);
    endtask

    task automatic chk(input string name, input logic [49:0] a, input logic [49:0] w);
        n_vec++;
        if (a !== w) begin
            n_err++;
            $display("FAIL %s: outputs {en,we,addr,wdata,cg,cd,lg,ld,rdata} got %b_%b_%h_%h_%b%b%b%b_%h, expected %b_%b_%h_%h_%b%b%b%b_%h",
                     name, a[49], a[48], a[47:36], a[35:20], a[19], a[18], a[17], a[16], a[15:0],
                     w[49], w[48], w[47:36], w[35:20], w[19], w[18], w[17], w[16], w[15:0]);
        end
    endtask

    task automatic chk1(input string name, input int a, input int w);
        n_vec++;
        if (a != w) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, a, w);
        end
    endtask

    initial begin
        int cnt;
        int lg_seen;
        n_vec = 0;
        n_err = 0;
        rst = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 12'h000; cpu_wdata = 16'h0000;
        ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = 12'h000; ldr_wdata = 16'h0000;
        mem_rdata = 16'h0000;
`ifdef MEM_ARB_LDR_LOCK_EN
        ldr_lock = 1'b0;
`endif

        // CPU read of 0x005 returning 0xBEEF
        v(1'b0, 1'b1, 1'b0, 12'h005, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000, 16'hBEEF, pk(1'b1, 1'b0, 12'h005, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000));
        v(1'b0, 1'b1, 1'b0, 12'h005, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000, 16'hBEEF, pk(1'b1, 1'b0, 12'h005, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000));
        v(1'b0, 1'b1, 1'b0, 12'h005, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000, 16'hBEEF, pk(1'b0, 1'b0, 12'h005, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'hBEEF));
        v(1'b0, 1'b0, 1'b0, 12'h005, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000, 16'hBEEF, pk(1'b0, 1'b0, 12'h005, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'hBEEF));

        // Reset, then both requesting continuously: C, L, C, L, C, L
        t2(1'b1, 16'h1111, pk(1'b1, 1'b0, 12'h010, 16'h5555, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000));
        t2(1'b0, 16'h1111, pk(1'b1, 1'b0, 12'h010, 16'h5555, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000));
        t2(1'b0, 16'h1111, pk(1'b0, 1'b0, 12'h010, 16'h5555, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1111));
        t2(1'b0, 16'h1111, pk(1'b0, 1'b0, 12'h010, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1111));
        t2(1'b0, 16'h1111, pk(1'b1, 1'b1, 12'h020, 16'hAAAA, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1111));
        t2(1'b0, 16'h1111, pk(1'b1, 1'b1, 12'h020, 16'hAAAA, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1111));
        t2(1'b0, 16'h1111, pk(1'b0, 1'b0, 12'h020, 16'hAAAA, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1111));
        t2(1'b0, 16'h1111, pk(1'b0, 1'b0, 12'h020, 16'hAAAA, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1111));
        t2(1'b0, 16'h2222, pk(1'b1, 1'b0, 12'h010, 16'h5555, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1111));
        t2(1'b0, 16'h2222, pk(1'b1, 1'b0, 12'h010, 16'h5555, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1111));
        t2(1'b0, 16'h2222, pk(1'b0, 1'b0, 12'h010, 16'h5555, 1'b1, 1'b1, 1'b0, 1'b0, 16'h2222));
        t2(1'b0, 16'h2222, pk(1'b0, 1'b0, 12'h010, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0, 16'h2222));
        t2(1'b0, 16'h2222, pk(1'b1, 1'b1, 12'h020, 16'hAAAA, 1'b0, 1'b0, 1'b1, 1'b0, 16'h2222));
        t2(1'b0, 16'h2222, pk(1'b1, 1'b1, 12'h020, 16'hAAAA, 1'b0, 1'b0, 1'b1, 1'b0, 16'h2222));
        t2(1'b0, 16'h2222, pk(1'b0, 1'b0, 12'h020, 16'hAAAA, 1'b0, 1'b0, 1'b1, 1'b1, 16'h2222));
        t2(1'b0, 16'h2222, pk(1'b0, 1'b0, 12'h020, 16'hAAAA, 1'b0, 1'b0, 1'b0, 1'b0, 16'h2222));
        t2(1'b0, 16'h3333, pk(1'b1, 1'b0, 12'h010, 16'h5555, 1'b1, 1'b0, 1'b0, 1'b0, 16'h2222));
        t2(1'b0, 16'h3333, pk(1'b1, 1'b0, 12'h010, 16'h5555, 1'b1, 1'b0, 1'b0, 1'b0, 16'h2222));
        t2(1'b0, 16'h3333, pk(1'b0, 1'b0, 12'h010, 16'h5555, 1'b1, 1'b1, 1'b0, 1'b0, 16'h3333));
        t2(1'b0, 16'h3333, pk(1'b0, 1'b0, 12'h010, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0, 16'h3333));
        t2(1'b0, 16'h3333, pk(1'b1, 1'b1, 12'h020, 16'hAAAA, 1'b0, 1'b0, 1'b1, 1'b0, 16'h3333));
        t2(1'b0, 16'h3333, pk(1'b1, 1'b1, 12'h020, 16'hAAAA, 1'b0, 1'b0, 1'b1, 1'b0, 16'h3333));
        t2(1'b0, 16'h3333, pk(1'b0, 1'b0, 12'h020, 16'hAAAA, 1'b0, 1'b0, 1'b1, 1'b1, 16'h3333));
        t2(1'b0, 16'h3333, pk(1'b0, 1'b0, 12'h020, 16'hAAAA, 1'b0, 1'b0, 1'b0, 1'b0, 16'h3333));

        // Loader write 0x1234 to 0x0FF; address/data changes after grant must be ignored, rdata kept
        v(1'b0, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b1, 12'h0FF, 16'h1234, 16'h3333, pk(1'b1, 1'b1, 12'h0FF, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 16'h3333));
        v(1'b0, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b1, 12'h3FF, 16'hFFFF, 16'h9999, pk(1'b1, 1'b1, 12'h0FF, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 16'h3333));
        v(1'b0, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b1, 12'h3FF, 16'hFFFF, 16'h9999, pk(1'b0, 1'b0, 12'h0FF, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b1, 16'h3333));
        v(1'b0, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000, 16'h9999, pk(1'b0, 1'b0, 12'h0FF, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 16'h3333));

        // CPU read of 0x0AB with req dropped right after the grant
        v(1'b0, 1'b1, 1'b0, 12'h0AB, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000, 16'h7777, pk(1'b1, 1'b0, 12'h0AB, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h3333));
        v(1'b0, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000, 16'h7777, pk(1'b1, 1'b0, 12'h0AB, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h3333));
        v(1'b0, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000, 16'h7777, pk(1'b0, 1'b0, 12'h0AB, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h7777));
        v(1'b0, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000, 16'h7777, pk(1'b0, 1'b0, 12'h0AB, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h7777));
        v(1'b0, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000, 16'h7777, pk(1'b0, 1'b0, 12'h0AB, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h7777));

        repeat (2) @(negedge clk);
        chk("reset_state", act, 50'd0);
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rb) begin
                rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
            end
            cpu_req = tbl[i].creq; cpu_we = tbl[i].cwe; cpu_addr = tbl[i].caddr; cpu_wdata = tbl[i].cwd;
            ldr_req = tbl[i].lreq; ldr_we = tbl[i].lwe; ldr_addr = tbl[i].laddr; ldr_wdata = tbl[i].lwd;
            mem_rdata = tbl[i].mrd;
            @(negedge clk);
            chk($sformatf("vec%0d", i), act, tbl[i].want);
        end

        // Reset asserted in the second BUSY cycle of a CPU read
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h040; cpu_wdata = 16'h0000; ldr_req = 1'b0;
        mem_rdata = 16'h4444;
        @(negedge clk);
        chk("rst_busy1", act, pk(1'b1, 1'b0, 12'h040, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h7777));
        @(negedge clk);
        chk("rst_busy2", act, pk(1'b1, 1'b0, 12'h040, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h7777));
        rst = 1'b0;
        #1;
        chk("rst_async_clear", act, 50'd0);
        @(negedge clk);
        chk("rst_held_no_done", act, 50'd0);
        rst = 1'b1;
        cpu_addr = 12'h041;
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 12'h0FE; ldr_wdata = 16'hBBBB;
        @(negedge clk);
        chk("rst_tie_cpu_wins", act, pk(1'b1, 1'b0, 12'h041, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000));
        cpu_req = 1'b0; ldr_req = 1'b0;
        cnt = 0;
        lg_seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (cpu_done) cnt++;
            if (ldr_gnt) lg_seen = 1;
        end
        chk1("rst_after_done_pulses", cnt, 1);
        chk1("rst_after_ldr_gnt_seen", lg_seen, 0);
        chk1("rst_after_rdata", int'(rdata), 32'h4444);

`ifdef MEM_ARB_LDR_LOCK_EN
        begin : lock_seq
            int   gl[$];
            int   k;
            logic pc, pl;
            int   got_cpu;
            k = 0; pc = 1'b0; pl = 1'b0; got_cpu = 0;
            cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 12'h0C0;
            ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 12'h100; ldr_wdata = 16'h0001; ldr_lock = 1'b1;
            for (int c = 0; c < 60 && got_cpu == 0; c++) begin
                @(negedge clk);
                if (ldr_gnt && !pl) begin
                    gl.push_back(1);
                    cpu_req = 1'b1;
                end
                if (cpu_gnt && !pc) gl.push_back(0);
                pl = ldr_gnt;
                pc = cpu_gnt;
                if (ldr_done) begin
                    k++;
                    case (k)
                        1: begin ldr_addr = 12'h101; ldr_wdata = 16'h0002; ldr_lock = 1'b1; end
                        2: begin ldr_addr = 12'h102; ldr_wdata = 16'h0003; ldr_lock = 1'b0; end
                        default: ldr_req = 1'b0;
                    endcase
                end
                if (cpu_done) begin
                    cpu_req = 1'b0;
                    got_cpu = 1;
                end
            end
            chk1("lock_cpu_done_seen", got_cpu, 1);
            chk1("lock_grant_count", gl.size(), 4);
            for (int i = 0; i < 4; i++) begin
                chk1($sformatf("lock_grant%0d_is_ldr", i), (i < gl.size()) ? gl[i] : -1, (i < 3) ? 1 : 0);
            end
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
